// File: rtl/bp_noc_link_pkg.sv
// Shared definitions for the bp_noc link pipeline.
// A link is packed MSB to LSB as {v, data[width-1:0], ready_and_rev},
// matching bsg_ready_and_link_sif.
package bp_noc_link_pkg;

   // Direction index within a channel.
   localparam bit DirA2B = 1'b0;
   localparam bit DirB2A = 1'b1;

   // Bit position of ready_and_rev within a link.
   localparam int unsigned LinkReadyBit = 0;

   // Total packed link width for a given payload width.
   function automatic int unsigned link_width(input int unsigned width);
      return 2 + width;
   endfunction

   // Bit position of v within a link.
   function automatic int unsigned link_v_bit(input int unsigned width);
      return width + 1;
   endfunction

endpackage

// File: rtl/bp_noc_link_stage.sv
// Two-entry elastic FIFO stage.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_v, i_data        enqueue side valid/data
//   o_ready            not full (no lookahead on a same-edge dequeue)
//   o_v, o_data        head of queue
//   i_ready            downstream ready
//   o_empty            occupancy is zero
module bp_noc_link_stage #(
   parameter int unsigned width_p = 64
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_v,
   input  logic [width_p-1:0] i_data,
   output logic               o_ready,
   output logic               o_v,
   output logic [width_p-1:0] o_data,
   input  logic               i_ready,
   output logic               o_empty
);

   logic [width_p-1:0] r_mem [2];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;
   logic               w_enq;
   logic               w_deq;

   assign o_ready = (r_count != 2'd2);
   assign o_v     = (r_count != 2'd0);
   assign o_empty = (r_count == 2'd0);
   assign o_data  = r_mem[r_rd_ptr];

   assign w_enq = i_v & o_ready;
   assign w_deq = o_v & i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_enq) r_wr_ptr <= ~r_wr_ptr;
         if (w_deq) r_rd_ptr <= ~r_rd_ptr;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge i_clk) begin
      if (w_enq) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/bp_noc_link_pipe.sv
// Multi-channel bidirectional ready/valid link pipeline with drain/quiesce
// and per-channel delivered-flit counters.
// Ports:
//   clk_i, reset_n_i          clock, async active-low reset
//   drain_i / drained_o       quiesce request / all stages empty under drain
//   side_A_links_i/_o         links from/to side A, {v, data, ready_and_rev}
//   side_B_links_i/_o         links from/to side B
//   a2b_count_o               flits delivered out of side B, per channel
//   b2a_count_o               flits delivered out of side A, per channel
module bp_noc_link_pipe
   import bp_noc_link_pkg::*;
#(
   parameter int unsigned width_p        = 64,
   parameter int unsigned num_channels_p = 5,
   parameter int unsigned num_stages_p   = 2,
   parameter int unsigned cnt_width_p    = 16
) (
   input  logic                                                clk_i,
   input  logic                                                reset_n_i,
   input  logic                                                drain_i,
   output logic                                                drained_o,
   input  logic [num_channels_p-1:0][link_width(width_p)-1:0] side_A_links_i,
   output logic [num_channels_p-1:0][link_width(width_p)-1:0] side_A_links_o,
   input  logic [num_channels_p-1:0][link_width(width_p)-1:0] side_B_links_i,
   output logic [num_channels_p-1:0][link_width(width_p)-1:0] side_B_links_o,
   output logic [num_channels_p-1:0][cnt_width_p-1:0]         a2b_count_o,
   output logic [num_channels_p-1:0][cnt_width_p-1:0]         b2a_count_o
);

   localparam int unsigned VBit = link_v_bit(width_p);
   localparam int unsigned NumEntries = num_channels_p * 2 * num_stages_p;

   if (num_stages_p < 1) begin : g_bad_stages
      $error("bp_noc_link_pipe: num_stages_p must be at least 1");
   end

   logic                   r_rst_done;
   logic                   w_ingress_open;
   logic [NumEntries-1:0]  w_stage_empty;
   logic                   w_eg_v    [num_channels_p][2];
   logic [width_p-1:0]     w_eg_data [num_channels_p][2];
   logic                   w_ing_rdy [num_channels_p][2];
   logic [cnt_width_p-1:0] w_cnt     [num_channels_p][2];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_rst_done <= 1'b0;
      else            r_rst_done <= 1'b1;
   end

   // Drain and the post-reset hold both close every ingress port at once.
   assign w_ingress_open = r_rst_done & ~drain_i;

   for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
      for (genvar d = 0; d < 2; d++) begin : g_dir
         logic                   w_v    [num_stages_p+1];
         logic                   w_rdy  [num_stages_p+1];
         logic [width_p-1:0]     w_data [num_stages_p+1];
         logic                   w_in_v;
         logic [width_p-1:0]     w_in_data;
         logic                   w_out_rdy;
         logic [cnt_width_p-1:0] r_count;

         if (d == 0) begin : g_a2b
            assign w_in_v    = side_A_links_i[c][VBit];
            assign w_in_data = side_A_links_i[c][width_p:1];
            assign w_out_rdy = side_B_links_i[c][LinkReadyBit];
         end else begin : g_b2a
            assign w_in_v    = side_B_links_i[c][VBit];
            assign w_in_data = side_B_links_i[c][width_p:1];
            assign w_out_rdy = side_A_links_i[c][LinkReadyBit];
         end

         // Gating v as well as ready keeps the first stage from enqueueing
         // a flit the sender was told was not taken.
         assign w_v[0]             = w_in_v & w_ingress_open;
         assign w_data[0]          = w_in_data;
         assign w_rdy[num_stages_p] = w_out_rdy;

         for (genvar s = 0; s < num_stages_p; s++) begin : g_stage
            bp_noc_link_stage #(.width_p(width_p)) u_stage (
               .i_clk   (clk_i),
               .i_rst_n (reset_n_i),
               .i_v     (w_v[s]),
               .i_data  (w_data[s]),
               .o_ready (w_rdy[s]),
               .o_v     (w_v[s+1]),
               .o_data  (w_data[s+1]),
               .i_ready (w_rdy[s+1]),
               .o_empty (w_stage_empty[(c*2+d)*num_stages_p+s])
            );
         end

         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) r_count <= '0;
            else if (w_v[num_stages_p] & w_rdy[num_stages_p])
               r_count <= r_count + 1'b1;
         end

         assign w_eg_v[c][d]    = w_v[num_stages_p];
         assign w_eg_data[c][d] = w_data[num_stages_p];
         assign w_ing_rdy[c][d] = w_rdy[0] & w_ingress_open;
         assign w_cnt[c][d]     = r_count;
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < num_channels_p; c++) begin
         side_A_links_o[c] = {w_eg_v[c][DirB2A], w_eg_data[c][DirB2A], w_ing_rdy[c][DirA2B]};
         side_B_links_o[c] = {w_eg_v[c][DirA2B], w_eg_data[c][DirA2B], w_ing_rdy[c][DirB2A]};
         a2b_count_o[c]    = w_cnt[c][DirA2B];
         b2a_count_o[c]    = w_cnt[c][DirB2A];
      end
   end

   assign drained_o = drain_i & r_rst_done & (&w_stage_empty);

endmodule

// File: doc/bp_noc_link_pipe.md
# bp_noc_link_pipe

Parametrised multi-channel, bidirectional ready/valid link pipeline that sits between adjacent tile routers, or between a tile and the memory edge, in the bp_top tile chain. It carries `num_channels_p` independent wormhole link channels through `num_stages_p` elastic two-entry stages per direction. It adds a drain/quiesce mode and per-channel delivered-flit counters, which a fixed-depth repeater does not provide.

## Interface
- `width_p`, default 64: link data payload width in bits.
- `num_channels_p`, default 5: number of independent links, e.g. req, resp, data_resp, cmd and data_cmd.
- `num_stages_p`, default 2: pipeline stages per direction. Must be at least 1; an elaboration assertion enforces this.
- `cnt_width_p`, default 16: width of each flit counter.
- `clk_i` input, 1 bit: clock. Everything is on its rising edge.
- `reset_n_i` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `drain_i` input, 1 bit: quiesce request.
- `drained_o` output, 1 bit: quiesce complete.
- `side_A_links_i` input, `[num_channels_p][2+width_p]`: link from side A.
- `side_A_links_o` output, `[num_channels_p][2+width_p]`: link to side A.
- `side_B_links_i` input, `[num_channels_p][2+width_p]`: link from side B.
- `side_B_links_o` output, `[num_channels_p][2+width_p]`: link to side B.
- `a2b_count_o` output, `[num_channels_p][cnt_width_p]`: flits delivered out of side B, per channel.
- `b2a_count_o` output, `[num_channels_p][cnt_width_p]`: flits delivered out of side A, per channel.
- Link packing, MSB to LSB: `{v, data[width_p-1:0], ready_and_rev}`.
- On an input link, `v` and `data` are forward traffic and `ready_and_rev` is the reverse ready for the matching output link.

## Operation
- Each channel has an A→B path and a B→A path. Each path is `num_stages_p` two-entry FIFO stages in series.
- The channels and directions are fully independent. No ordering or arbitration exists across them.
- Transfer rule: a flit moves when `v` and the receiver's `ready_and` are both high at the same rising edge.
- A sender's `v` may precede `ready_and`. There is no combinational path from any `v` input to any `ready_and` output.
- Ingress ready, e.g. `side_A_links_o[c].ready_and_rev`, equals first stage not full AND NOT `drain_i` AND `rst_done`.
- `rst_done` is a register: cleared by reset, set on the first rising edge after `reset_n_i` rises.
- Egress `v`/`data` come from the head of the last stage, e.g. `side_B_links_o[c].v` and `.data`. Egress is never gated by drain.
- Flits within one path are delivered in order, with no loss or duplication.
- `a2b_count_o[c]` increments on each side-B egress handshake. `b2a_count_o[c]` increments on each side-A egress handshake.
- Counters wrap modulo 2^`cnt_width_p` with no saturation or flag.
- Drain: `drain_i` high blocks new ingress on every channel, in both directions, in the same cycle. In-flight flits continue to egress.
- `drained_o` = `drain_i` AND all stages empty. It is combinational from registered occupancy and `drain_i`.
- Deasserting `drain_i` reopens ingress immediately. Flits are neither dropped nor reordered by drain.

## Timing
- Reset, with `reset_n_i` low: asynchronously empties all stages and zeroes all counters.
- During reset and for the first cycle after release, every `v` output and every `ready_and_rev` output is 0.
- `drained_o` is 0 during reset. It may be 1 afterwards only if `drain_i` is high.
- Latency: a flit accepted at ingress edge k is presented as egress `v` in the cycle after edge k+`num_stages_p`-1, i.e. `num_stages_p` cycles. Reset mid-traffic discards all in-flight flits.
- Throughput: 1 flit/cycle/path sustained with receiver ready continuously high.
- Stalls: with egress ready held low, a path accepts exactly 2·`num_stages_p` flits, then drops ingress ready.
- Simultaneous enqueue and dequeue on a full stage: the dequeue frees the slot at the same edge. The stage's ready still reflects the pre-edge full state, so it sees no combinational lookahead.
- Simultaneous `drain_i` rise and ingress `v`: no transfer occurs, because ready is already low.

## Structure
- Shared package `bp_noc_link_pkg`: the link struct macro `{v, data, ready_and_rev}` and a width helper `2+width_p`. This matches `bsg_ready_and_link_sif`.
- Sub-module `bp_noc_link_stage`: a two-entry elastic FIFO with `width_p`, async active-low reset, ready = not full, and an empty output.
- Top level: generate loops over channels, directions and stages; counters; drain and `rst_done` logic.

## Test plan
- Single flit, `num_stages_p`=3: A ingress 0xA5 accepted at cycle 0 → `side_B_links_o.v` is high at cycle 3 carrying 0xA5, and `a2b_count_o` goes 0→1.
- Backpressure, `num_stages_p`=2, B ready held low: A accepts exactly 4 flits, then ready drops to 0. Releasing B ready → 4 flits delivered in order, then ingress reopens.
- Full stream: 100 flits per direction on all 5 channels, receivers always ready → all delivered by cycle 100+`num_stages_p`, and every counter reads 100.
- Drain mid-stream with 3 flits in flight: ingress ready falls in the same cycle, the 3 flits egress, then `drained_o` rises. Deasserting drain → traffic resumes with no loss.
- Counter wrap, `cnt_width_p`=4: 17 flits delivered → count reads 1.
- `reset_n_i` pulsed low mid-stream, asynchronously: all `v` outputs go 0 before the next edge, counters read 0, and in-flight flits are gone. Ready stays 0 until the first edge after release.
